// File: rtl/color_pkg.sv
// Shared colour and sprite geometry definitions for the sprite path.
package color_pkg;

  // One RGB444 pixel, red in the top nibble.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int SPRITE_DIM    = 16;
  localparam int SPRITE_PIXELS = SPRITE_DIM * SPRITE_DIM;
  localparam int SPRITE_BYTES  = (SPRITE_PIXELS * 12) / 8;

  localparam logic [11:0] TRANSPARENT_RGB444 = 12'h000;

endpackage

// File: rtl/sprite_byte_unpacker.sv
// Turns a stream of payload bytes into RGB444 pixels, three bytes -> two pixels.
// Byte 0 is the high byte of P0, byte 1 splits into P0 low nibble / P1 high
// nibble, byte 2 is the low byte of P1. pix_valid is combinational with the
// byte that completes a pixel so the caller can register it into the write port.
module sprite_byte_unpacker
  import color_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       pix_valid,
  output rgb444_t    pix_data
);

  logic [1:0] phase;
  logic [7:0] hi;
  logic [3:0] nib;

  // Phase counter plus the partial-pixel holding registers.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase <= 2'd0;
      hi    <= 8'h00;
      nib   <= 4'h0;
    end else if (byte_valid) begin
      case (phase)
        2'd0: begin
          hi    <= byte_data;
          phase <= 2'd1;
        end
        2'd1: begin
          nib   <= byte_data[3:0];
          phase <= 2'd2;
        end
        default: phase <= 2'd0;
      endcase
    end
  end

  // Phases 1 and 2 each complete one pixel.
  always_comb begin
    pix_valid = byte_valid && (phase != 2'd0);
    if (phase == 2'd1) pix_data = {hi, byte_data[7:4]};
    else               pix_data = {nib, byte_data};
  end

endmodule

// File: rtl/sprite_loader.sv
// Sprite loader: parses host-link frames [SYNC_BYTE, slot, 384 payload bytes]
// and writes 256 RGB444 pixels into the sprite RAM write port at {slot, y, x}.
// Handshake: a byte transfers on any rising edge where s_valid && s_ready;
// s_ready is registered and low only in FINISH, so a frame is never stalled.
// Optional feature macro SPRITE_LOADER_CHECKSUM_EN adds a trailing XOR byte
// (slot byte ^ all payload bytes) checked in state CSUM.
module sprite_loader
  import color_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         NUM_SLOTS  = 2,
  parameter int         SLOT_W     = 1,
  parameter int         NUM_PIXELS = SPRITE_PIXELS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              abort,
  output logic              wr_en,
  output logic [SLOT_W+7:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLOT,
    ST_PIXEL,
`ifdef SPRITE_LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_FINISH
  } loader_state_t;

  localparam logic [8:0] LAST_PIX = 9'(NUM_PIXELS - 1);

  loader_state_t     state;
  logic [SLOT_W-1:0] slot;
  logic [8:0]        pix_cnt;
  logic              accept;
  logic              unpack_valid;
  logic              unpack_clear;
  logic              pix_valid;
  rgb444_t           pix_data;
`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept = s_valid && s_ready;
  // Bytes reach the unpacker only in PIXEL; anything else (incl. abort) resets its phase.
  assign unpack_valid = accept && (state == ST_PIXEL) && !abort;
  assign unpack_clear = (state != ST_PIXEL) || abort;

  sprite_byte_unpacker u_unpacker (
    .clk        (clk),
    .reset      (reset),
    .clear      (unpack_clear),
    .byte_valid (unpack_valid),
    .byte_data  (s_data),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data)
  );

  // Frame FSM with registered handshake, status pulses and RAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      slot    <= '0;
      pix_cnt <= 9'd0;
      s_ready <= 1'b1;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 12'h000;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      csum    <= 8'h00;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      if (abort && state != ST_IDLE) begin
        // Abort drops the frame and any byte that transferred this cycle.
        state   <= ST_IDLE;
        s_ready <= 1'b1;
        busy    <= 1'b0;
        err     <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept && s_data == SYNC_BYTE) begin
              state <= ST_SLOT;
              busy  <= 1'b1;
            end
          end
          ST_SLOT: begin
            if (accept) begin
              if (32'(s_data) < 32'(NUM_SLOTS)) begin
                slot    <= s_data[SLOT_W-1:0];
                pix_cnt <= 9'd0;
                state   <= ST_PIXEL;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                csum    <= s_data;
`endif
              end else begin
                err   <= 1'b1;
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          ST_PIXEL: begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
            if (accept) csum <= csum ^ s_data;
`endif
            if (pix_valid) begin
              wr_en   <= 1'b1;
              wr_addr <= {slot, pix_cnt[7:0]};
              wr_data <= pix_data;
              pix_cnt <= pix_cnt + 9'd1;
              if (pix_cnt == LAST_PIX) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                state   <= ST_CSUM;
`else
                state   <= ST_FINISH;
                s_ready <= 1'b0;
`endif
              end
            end
          end
`ifdef SPRITE_LOADER_CHECKSUM_EN
          ST_CSUM: begin
            if (accept) begin
              if (s_data == csum) done <= 1'b1;
              else                err  <= 1'b1;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
`endif
          ST_FINISH: begin
            done    <= 1'b1;
            state   <= ST_IDLE;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
          default: begin
            state   <= ST_IDLE;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
